// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: per-channel input conditioner. Each bit passes through an
// N-stage synchroniser, a stability filter, and registered rise/fall pulse logic.
module sync_debounce_edge #(
    parameter int               WIDTH           = 4,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 3,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s        [STAGES];
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // Only s[0] ever samples d; everything downstream sees the last stage.
    assign sync = s[STAGES-1];

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        q_next = q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync[i] != q[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    q_next[i] = sync[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
        rise_next = q_next & ~q;
        fall_next = q & ~q_next;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                s[k] <= RESET_VAL;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            q          <= RESET_VAL;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else if (en) begin
            s[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                s[k] <= s[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            q          <= q_next;
            rise       <= rise_next;
            fall       <= fall_next;
            any_change <= |(rise_next | fall_next);
        end else begin
            // Frozen: state holds, but a pending pulse must not stretch.
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: directed vector table plus randomized run against a
// history-based reference model, over three parameter sets.
module tb_sync_debounce_edge;

    logic       clk;
    logic       Reset;
    logic       en;
    logic [3:0] d;

    logic [3:0] q_w  [3];
    logic [3:0] r_w  [3];
    logic [3:0] f_w  [3];
    logic       a_w  [3];

    int         cs   [3];
    int         cd   [3];
    logic [3:0] crv  [3];

    int n_cmp = 0;
    int n_bad = 0;

    sync_debounce_edge #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(3), .RESET_VAL(4'h0)) dut0 (
        .clk(clk), .Reset(Reset), .en(en), .d(d),
        .q(q_w[0]), .rise(r_w[0]), .fall(f_w[0]), .any_change(a_w[0]));

    sync_debounce_edge #(.WIDTH(4), .STAGES(3), .DEBOUNCE_CYCLES(3), .RESET_VAL(4'h0)) dut1 (
        .clk(clk), .Reset(Reset), .en(en), .d(d),
        .q(q_w[1]), .rise(r_w[1]), .fall(f_w[1]), .any_change(a_w[1]));

    sync_debounce_edge #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(4'h5)) dut2 (
        .clk(clk), .Reset(Reset), .en(en), .d(d),
        .q(q_w[2]), .rise(r_w[2]), .fall(f_w[2]), .any_change(a_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: hist[] holds every d value sampled on an enabled edge since
    // the last reset. A bit of q flips once the D most recent synchronised samples
    // (d delayed by STAGES sampled edges) all disagree with q, and all of them were
    // taken after q's previous change.
    logic [3:0] hist [4096];
    int         hn;
    logic       mvalid = 1'b0;
    logic [3:0] mq   [3];
    logic [3:0] mr   [3];
    logic [3:0] mf   [3];
    int         lc   [3][4];

    function automatic logic sample_at(input int c, input int j, input int i);
        return (j >= 1) ? hist[j][i] : crv[c][i];
    endfunction

    task automatic model_edge(input logic rst, input logic e, input logic [3:0] dv);
        logic [3:0] nq;
        logic       stable;
        if (rst) begin
            hn     = 0;
            mvalid = 1'b1;
            for (int c = 0; c < 3; c++) begin
                mq[c] = crv[c];
                mr[c] = 4'h0;
                mf[c] = 4'h0;
                for (int i = 0; i < 4; i++) lc[c][i] = 0;
            end
        end else if (!e) begin
            for (int c = 0; c < 3; c++) begin
                mr[c] = 4'h0;
                mf[c] = 4'h0;
            end
        end else begin
            hn       = hn + 1;
            hist[hn] = dv;
            for (int c = 0; c < 3; c++) begin
                nq = mq[c];
                for (int i = 0; i < 4; i++) begin
                    stable = 1'b1;
                    for (int k = 0; k < cd[c]; k++) begin
                        if (sample_at(c, hn - cs[c] - k, i) == mq[c][i] || (hn - k) <= lc[c][i])
                            stable = 1'b0;
                    end
                    if (stable) begin
                        nq[i]    = ~mq[c][i];
                        lc[c][i] = hn;
                    end
                end
                mr[c] = nq & ~mq[c];
                mf[c] = ~nq & mq[c];
                mq[c] = nq;
            end
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the model, then compare all DUTs 1 time unit later.
    task automatic step(input logic r, input logic e, input logic [3:0] dv);
        Reset = r;
        en    = e;
        d     = dv;
        @(posedge clk);
        model_edge(r, e, dv);
        #1;
        if (mvalid) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("model cfg%0d q", c),    q_w[c], mq[c]);
                check($sformatf("model cfg%0d rise", c), r_w[c], mr[c]);
                check($sformatf("model cfg%0d fall", c), f_w[c], mf[c]);
                check($sformatf("model cfg%0d any", c),  {3'b0, a_w[c]}, {3'b0, |(mr[c] | mf[c])});
                check($sformatf("cfg%0d rise&fall", c),  r_w[c] & f_w[c], 4'h0);
            end
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic [3:0] f;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n, input logic rst, input logic e, input logic [3:0] dv,
                                input logic [3:0] eq, input logic [3:0] er, input logic [3:0] ef);
        vec_t v;
        v.rst = rst; v.en = e; v.d = dv; v.q = eq; v.r = er; v.f = ef;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] dr;

        cs[0] = 2; cd[0] = 3; crv[0] = 4'h0;
        cs[1] = 3; cd[1] = 3; crv[1] = 4'h0;
        cs[2] = 2; cd[2] = 1; crv[2] = 4'h5;
        Reset = 1'b1;
        en    = 1'b1;
        d     = 4'hF;

        // Reset release with d=F: rise on the 5th edge after release.
        add(3, 1, 1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(4, 0, 1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1, 4'hF, 4'hF, 4'hF, 4'h0);
        add(2, 0, 1, 4'hF, 4'hF, 4'h0, 4'h0);
        // Fall path from q=F.
        add(4, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0);
        add(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'hF);
        add(2, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        // Two-cycle glitch on d[0] is rejected.
        add(2, 0, 1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(6, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        // Three-cycle pulse passes: rise at edge 5, fall at edge 8.
        add(3, 0, 1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1, 4'h0, 4'h1, 4'h1, 4'h0);
        add(2, 0, 1, 4'h0, 4'h1, 4'h0, 4'h0);
        add(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h1);
        add(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        // Reach q=0101, then simultaneous rise/fall to 0011.
        add(4, 0, 1, 4'h5, 4'h0, 4'h0, 4'h0);
        add(1, 0, 1, 4'h5, 4'h5, 4'h5, 4'h0);
        add(2, 0, 1, 4'h5, 4'h5, 4'h0, 4'h0);
        add(4, 0, 1, 4'h3, 4'h5, 4'h0, 4'h0);
        add(1, 0, 1, 4'h3, 4'h3, 4'h2, 4'h4);
        add(1, 0, 1, 4'h3, 4'h3, 4'h0, 4'h0);

        for (int v = 0; v < vecs.size(); v++) begin
            step(vecs[v].rst, vecs[v].en, vecs[v].d);
            check($sformatf("vec%0d q", v),    q_w[0], vecs[v].q);
            check($sformatf("vec%0d rise", v), r_w[0], vecs[v].r);
            check($sformatf("vec%0d fall", v), f_w[0], vecs[v].f);
            check($sformatf("vec%0d any", v),  {3'b0, a_w[0]}, {3'b0, |(vecs[v].r | vecs[v].f)});
        end

        // Enable freeze: d toggles while en=0, then held at A with en=1.
        for (int t = 0; t < 10; t++) begin
            step(1'b0, 1'b0, t[0] ? 4'h0 : 4'hA);
            check($sformatf("freeze%0d q", t),    q_w[0], 4'h3);
            check($sformatf("freeze%0d pulse", t), r_w[0] | f_w[0], 4'h0);
        end
        for (int t = 1; t <= 6; t++) begin
            step(1'b0, 1'b1, 4'hA);
            check($sformatf("resume%0d q", t),    q_w[0], (t >= 5) ? 4'hA : 4'h3);
            check($sformatf("resume%0d rise", t), r_w[0], (t == 5) ? 4'h8 : 4'h0);
            check($sformatf("resume%0d fall", t), f_w[0], (t == 5) ? 4'h1 : 4'h0);
        end

        // Mid-operation reset at edge 4, before q can update.
        for (int t = 1; t <= 3; t++) step(1'b0, 1'b1, 4'hF);
        for (int t = 0; t < 2; t++) begin
            step(1'b1, 1'b1, 4'hF);
            check($sformatf("midrst%0d q", t),     q_w[0], 4'h0);
            check($sformatf("midrst%0d pulse", t), r_w[0] | f_w[0], 4'h0);
        end
        for (int t = 1; t <= 7; t++) begin
            step(1'b0, 1'b1, 4'hF);
            check($sformatf("release%0d s2 rise", t), r_w[0], (t == 5) ? 4'hF : 4'h0);
            check($sformatf("release%0d s3 rise", t), r_w[1], (t == 6) ? 4'hF : 4'h0);
        end

        // Randomized run: slowly changing inputs, occasional freezes and resets.
        dr = 4'hF;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) dr[i] = ~dr[i];
            end
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, dr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Parametrised multi-channel input conditioner; successor to the single sync-reset flop.
- Per bit: an N-stage synchroniser chain, then a stability (debounce) filter, then registered one-cycle rise/fall pulses.
- Sits between asynchronous board inputs (switches, keys, GPIO) and the synchronous FSMs of the lab designs.

Parameters:
- WIDTH, 4, number of independent channels.
- STAGES, 2, synchroniser flops per channel; legal values are 2 or more.
- DEBOUNCE_CYCLES, 3, consecutive cycles the synchronised value must differ from q before q updates; legal values are 1 or more.
- RESET_VAL, 0, WIDTH-bit value loaded into q on reset.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; low freezes all state.
- d  input  WIDTH  asynchronous raw inputs.
- q  output  WIDTH  synchronised, debounced level.
- rise  output  WIDTH  one-cycle pulse per bit on a q 0->1 change.
- fall  output  WIDTH  one-cycle pulse per bit on a q 1->0 change.
- any_change  output  1  OR of (rise | fall).

Behaviour:
- Reset is synchronous and active-high, on clock clk.
- Reset values, while Reset is sampled high at a rising edge:
  - all sync stages load RESET_VAL;
  - q loads RESET_VAL;
  - all counters load 0;
  - rise, fall and any_change load 0.
- Reset has priority over en.
- Sync chain, per bit i, when en=1:
  - s[0][i] <= d[i]; s[k][i] <= s[k-1][i];
  - sync[i] = s[STAGES-1][i].
- Debounce counter, per bit:
  - cnt[i] is clog2(DEBOUNCE_CYCLES+1) bits wide.
  - If sync[i]==q[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: q[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any reversion of sync to q before the count completes clears the count, so no partial credit carries over.
- Latency: a level on d held stable appears on q on the (STAGES+DEBOUNCE_CYCLES)th rising edge after it is first sampled. Example: 5 edges at STAGES=2, DEBOUNCE_CYCLES=3.
- DEBOUNCE_CYCLES=1 degenerates to q following sync with one register of delay.
- Edge pulses, per bit:
  - rise/fall are registered in the same cycle q updates, so rise[i] is high in exactly the first cycle q[i] reads 1; fall likewise for 0.
  - Pulses are exactly one cycle wide.
  - Rise and fall on different bits in the same cycle are allowed and independent.
  - rise[i] and fall[i] are never both high.
- en=0:
  - sync stages, counters and q hold their values;
  - rise, fall and any_change are forced to 0 on the next edge;
  - d changes during en=0 are ignored until en returns high; the chain then resumes from its held contents.
- Reset mid-operation:
  - in-flight counts are discarded;
  - after release, all transitions are measured relative to RESET_VAL;
  - if d differs from RESET_VAL at release, the corresponding pulse fires STAGES+DEBOUNCE_CYCLES edges after release.
- Metastability: no combinational path from d to any output; only s[0] samples d.

Test Plan:
All scenarios use WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=3, RESET_VAL=0, en=1 unless stated.
- Reset release: hold Reset for 3 cycles with d=4'hF, then release.
  - Required: q=0 and no pulses during reset.
  - Required: rise=4'hF and any_change=1 for exactly one cycle, on the 5th edge after release.
  - Required: q=4'hF from that edge onward.
- Glitch rejection: from q=0, pulse d[0]=1 for 2 cycles, then 0.
  - Required: q stays 4'h0; rise and fall stay 0 throughout.
  - Repeat with a 3-cycle pulse. Required: rise[0] fires 5 edges after the first sample; fall[0] fires 3 cycles later.
- Fall path: from q=4'hF, set d=4'h0 and hold.
  - Required: fall=4'hF for one cycle on the 5th edge; q=4'h0 thereafter; rise=0 throughout.
- Simultaneous channels: from q=4'b0101, set d=4'b0011 in one cycle.
  - Required: rise=4'b0010 and fall=4'b0100 in the same single cycle; q becomes 4'b0011.
- Enable freeze: set en=0, toggle d=4'hA for 10 cycles, then hold d=4'hA and set en=1.
  - Required: q unchanged and pulses 0 while en=0.
  - Required: after en rises, q=4'hA on the 5th edge with a matching single rise/fall pulse.
- Mid-operation reset: set d=4'hF, then assert Reset at edge 4, before q updates.
  - Required: q=0, counters cleared, no pulse during reset.
  - Required: after release with d=4'hF held, rise=4'hF on the 5th edge.
  - Rerun with STAGES=3. Required: that edge becomes the 6th.
